horizontal_tf_mul_row2: RTL and testbench
=========================================

Name: horizontal_tf_mul_row2

Overview:
- Consumer end of the row-2 horizontal twiddle-factor path.
- Takes one 64-bit data word per cycle from the radix-16 butterfly row-2 output, together with the twiddle factor presented by the row-2 horizontal twiddle generator.
- Returns data*tf mod p, where p = 2^64 - 2^32 + 1 (Goldilocks), through a 3-stage pipeline. The pipeline tracks point-in-group and group index, so downstream stages can align their writes.

Parameters:
- P_WIDTH, 64, data/twiddle width (fixed; the reduction is only defined for 64).
- SC_WIDTH, 3, stage_counter width.
- GRP_WIDTH, 6, group-index width (64 groups of 16 points).
- LAT, 3, pipeline depth (informational; RTL is fixed at 3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-high.
- CEN  in  1  active-low enable. When high, the entire pipeline and all counters hold.
- stage_counter  in  SC_WIDTH  current FFT stage. The multiply is applied only when this is 0; otherwise the block bypasses.
- in_valid  in  1  in_data/tf valid this cycle.
- in_data  in  P_WIDTH  butterfly output word.
- tf  in  P_WIDTH  twiddle factor aligned to in_data (alignment is upstream's responsibility).
- out_valid  out  1  out_data valid.
- out_data  out  P_WIDTH  product mod p, or bypassed data.
- out_pt_idx  out  4  point index within group (0..15) of out_data.
- out_grp_idx  out  GRP_WIDTH  group index of out_data.
- out_last  out  1  high with the last point (pt 15) of group 63.

Behaviour:
- Reset: all pipeline registers, out_valid, out_data, out_pt_idx, out_grp_idx, out_last and the internal counters clear to 0. Reset mid-stream discards all in-flight data; the first valid accepted after reset is pt 0, grp 0.
- Advance: the pipeline shifts only on cycles with CEN=0. With CEN=1, outputs hold their values, including out_valid.
- Latency: a word accepted (CEN=0, in_valid=1) at edge N appears with out_valid=1 after the 3rd advancing edge. Bubbles (in_valid=0) propagate as out_valid=0.
- Counters:
  - pt_cnt (4b) increments per accepted word and wraps 15->0.
  - grp_cnt increments when pt_cnt wraps and wraps 63->0.
  - Counters advance in every stage_counter value.
  - Both counter values are captured with the word and travel down the pipe.
- Bypass: the word passes through unchanged, with the same 3-cycle latency, when either:
  - stage_counter != 0, or
  - pt_cnt == 0 at capture (twiddle index 0 is unity by definition; the tf value is ignored).
  - The bypass flag is captured at stage 1.
- Input canonicalisation (stage 1): any in_data or tf >= p has p subtracted once before multiplying.
- Stage 1: registers the 128-bit product x = a*b, plus bypass/valid/indices.
- Stage 2:
  - Split x = xh*2^64 + xl, with xh = c*2^32 + d (c, d 32b).
  - t0 = xl - c. On borrow, subtract a further 2^32-1 (equivalently add p).
  - t1 = (d<<32) - d.
  - Register t0 and t1.
- Stage 3:
  - s = t0 + t1 computed 65b wide. On carry-out, add 2^32-1.
  - If the result is >= p, subtract p.
  - The output is always canonical (< p).
- out_last = out_valid & (out_pt_idx == 15) & (out_grp_idx == 63).
- Simultaneous CEN=1 and in_valid=1: the word is not accepted and the counters do not move.
- A stage_counter change mid-group does not reset the counters. Only the per-word bypass flag changes.

Decomposition:
- Shared package: GOLDILOCKS_P (64'hFFFFFFFF00000001), EPS (64'h00000000FFFFFFFF), P_WIDTH, GRP_WIDTH, POINTS_PER_GRP=16.
- Sub-module goldilocks_reduce128: stages 2-3, pipelined, carrying a sideband bus for valid, bypass and indices. It is reusable by the vertical twiddle multipliers.

Test Plan:
- Reset, then 16 words in_data=5 with tf=64'h4a3f9ccc62d9a86a, stage_counter=0:
  - pt 0 -> out_data=5 (bypass).
  - pt 1..15 -> 5*tf mod p, out_pt_idx 0..15, grp 0.
  - First out_valid exactly 3 edges after the first accept.
- Corner products, with pt_cnt != 0 and stage_counter=0:
  - p-1 * p-1 -> 1.
  - 2^32 * 2^32 -> 64'h00000000FFFFFFFF.
  - 2^48 * 2^48 -> 64'hFFFFFFFF00000000.
  - in_data=64'hFFFFFFFFFFFFFFFF (non-canonical) * 1 -> 64'h00000000FFFFFFFE.
- stage_counter=2 over a full group with arbitrary tf -> out_data equals in_data for all 16 words, at latency 3.
- CEN toggled high for 5 cycles mid-stream, with in_valid held -> outputs frozen, no duplicates or drops, and the order and indices are preserved after resume.
- 1024 back-to-back accepts:
  - out_grp_idx wraps 63->0.
  - out_last pulses exactly once, on the 1024th output.
  - A random golden-model check of every product.
- Assert rst_n for 1 cycle with 2 words in flight -> out_valid drops to 0 immediately (asynchronously). The next accepted word reports pt 0, grp 0.

Source files
------------

// File: rtl/horizontal_tf_mul_row2_pkg.sv
// Shared constants and sideband types for the Goldilocks twiddle multipliers.
// p = 2^64 - 2^32 + 1; EPS = 2^64 mod p.
package horizontal_tf_mul_row2_pkg;

    localparam int P_WIDTH        = 64;
    localparam int GRP_WIDTH      = 6;
    localparam int PT_WIDTH       = 4;
    localparam int POINTS_PER_GRP = 16;
    localparam int LAT            = 3;

    localparam logic [P_WIDTH-1:0] GOLDILOCKS_P = 64'hFFFFFFFF00000001;
    localparam logic [P_WIDTH-1:0] EPS          = 64'h00000000FFFFFFFF;

    typedef struct packed {
        logic                 vld;
        logic [PT_WIDTH-1:0]  pt;
        logic [GRP_WIDTH-1:0] grp;
    } tag_t;

    typedef struct packed {
        tag_t tag;
        logic bypass;
    } sideband_t;

endpackage

// File: rtl/horizontal_tf_mul_row2_reduce128.sv
// Two-stage pipelined reduction of a 128-bit product modulo the Goldilocks prime.
// Bypassed words arrive as {64'h0, word} and leave untouched, even when non-canonical.
module goldilocks_reduce128
    import horizontal_tf_mul_row2_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [2*P_WIDTH-1:0]   x,
    input  sideband_t              sb_in,
    output logic [P_WIDTH-1:0]     data,
    output tag_t                   sb_out
);

    // 2^96 == -1 (mod p), so the top 32 bits are subtracted from the low word.
    function automatic logic [P_WIDTH-1:0] fold_high(input logic [2*P_WIDTH-1:0] v);
        logic [31:0]      c;
        logic [P_WIDTH:0] diff;
        c    = v[127:96];
        diff = {1'b0, v[63:0]} - {33'd0, c};
        return diff[P_WIDTH] ? (diff[P_WIDTH-1:0] - EPS) : diff[P_WIDTH-1:0];
    endfunction

    function automatic logic [P_WIDTH-1:0] fold_mid(input logic [2*P_WIDTH-1:0] v);
        logic [31:0] d;
        d = v[95:64];
        return {d, 32'd0} - {32'd0, d};
    endfunction

    function automatic logic [P_WIDTH-1:0] final_sum(input logic [P_WIDTH-1:0] a,
                                                      input logic [P_WIDTH-1:0] b,
                                                      input logic              bypass);
        logic [P_WIDTH:0]   s;
        logic [P_WIDTH-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = s[P_WIDTH] ? (s[P_WIDTH-1:0] + EPS) : s[P_WIDTH-1:0];
        if (!bypass && (r >= GOLDILOCKS_P)) begin
            r = r - GOLDILOCKS_P;
        end
        return r;
    endfunction

    logic [P_WIDTH-1:0] t0_p2;
    logic [P_WIDTH-1:0] t1_p2;
    sideband_t          sb_p2;

    // stage 2: partial folds
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            t0_p2 <= '0;
            t1_p2 <= '0;
            sb_p2 <= '0;
        end else if (en) begin
            t0_p2 <= fold_high(x);
            t1_p2 <= fold_mid(x);
            sb_p2 <= sb_in;
        end
    end

    // stage 3: final add and canonicalisation
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data   <= '0;
            sb_out <= '0;
        end else if (en) begin
            data   <= final_sum(t0_p2, t1_p2, sb_p2.bypass);
            sb_out <= sb_p2.tag;
        end
    end

endmodule

// File: rtl/horizontal_tf_mul_row2.sv
// Row-2 horizontal twiddle multiplier: out = in_data * tf mod p, 3-cycle pipeline,
// tagged with point/group indices; bypass for stage_counter != 0 and point 0.
module horizontal_tf_mul_row2 #(
    parameter int P_WIDTH   = 64,
    parameter int SC_WIDTH  = 3,
    parameter int GRP_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 CEN,
    input  logic [SC_WIDTH-1:0]  stage_counter,
    input  logic                 in_valid,
    input  logic [P_WIDTH-1:0]   in_data,
    input  logic [P_WIDTH-1:0]   tf,
    output logic                 out_valid,
    output logic [P_WIDTH-1:0]   out_data,
    output logic [3:0]           out_pt_idx,
    output logic [GRP_WIDTH-1:0] out_grp_idx,
    output logic                 out_last
);
    import horizontal_tf_mul_row2_pkg::*;

    function automatic logic [P_WIDTH-1:0] canon(input logic [P_WIDTH-1:0] v);
        return (v >= GOLDILOCKS_P) ? (v - GOLDILOCKS_P) : v;
    endfunction

    logic [3:0]           pt_cnt;
    logic [GRP_WIDTH-1:0] grp_cnt;
    logic                 accept;
    logic                 bypass;
    logic [2*P_WIDTH-1:0] prod;
    logic [2*P_WIDTH-1:0] x_p1;
    sideband_t            sb_p1;
    tag_t                 tag_p3;

    assign accept = !CEN && in_valid;
    // Twiddle index 0 is unity, so point 0 of every group skips the multiply.
    assign bypass = (stage_counter != '0) || (pt_cnt == '0);
    assign prod   = {{P_WIDTH{1'b0}}, canon(in_data)} * {{P_WIDTH{1'b0}}, canon(tf)};

    // stage 1: canonicalise, multiply, capture indices
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            x_p1    <= '0;
            sb_p1   <= '0;
            pt_cnt  <= '0;
            grp_cnt <= '0;
        end else if (!CEN) begin
            x_p1  <= bypass ? {{P_WIDTH{1'b0}}, in_data} : prod;
            sb_p1 <= '{tag: '{vld: in_valid, pt: pt_cnt, grp: grp_cnt}, bypass: bypass};
            if (accept) begin
                pt_cnt <= pt_cnt + 1'b1;
                if (pt_cnt == 4'(POINTS_PER_GRP - 1)) begin
                    grp_cnt <= grp_cnt + 1'b1;
                end
            end
        end
    end

    goldilocks_reduce128 u_reduce (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (!CEN),
        .x      (x_p1),
        .sb_in  (sb_p1),
        .data   (out_data),
        .sb_out (tag_p3)
    );

    assign out_valid   = tag_p3.vld;
    assign out_pt_idx  = tag_p3.pt;
    assign out_grp_idx = tag_p3.grp;
    assign out_last    = tag_p3.vld && (tag_p3.pt == 4'hF) && (tag_p3.grp == '1);

endmodule

// File: tb/tb_horizontal_tf_mul_row2.sv
// Scoreboard bench for horizontal_tf_mul_row2: expected words queued at drive time,
// compared per advancing edge; held outputs checked during CEN stalls.
module tb_horizontal_tf_mul_row2;

    localparam logic [63:0] P  = 64'hFFFFFFFF00000001;
    localparam logic [63:0] TF = 64'h4a3f9ccc62d9a86a;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cen = 1'b0;
    logic [2:0]  stage_counter = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] tf = '0;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  out_pt_idx;
    logic [5:0]  out_grp_idx;
    logic        out_last;

    always #5 clk = ~clk;

    horizontal_tf_mul_row2 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CEN           (cen),
        .stage_counter (stage_counter),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .tf            (tf),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_pt_idx    (out_pt_idx),
        .out_grp_idx   (out_grp_idx),
        .out_last      (out_last)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  pt;
        logic [5:0]  grp;
        logic        last;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          adv_cnt = 0;
    int          adv_seen = 0;
    int          last_cnt = 0;
    bit          mon_en = 1'b0;
    logic        exp_v;
    logic        held_v = 1'b0;
    logic [63:0] held_d = '0;
    logic [3:0]  pt_m = '0;
    logic [5:0]  grp_m = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    function automatic logic [63:0] mod_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pw;
        logic [127:0] r;
        pw = {64'd0, P};
        r  = ({64'd0, a} % pw) * ({64'd0, b} % pw);
        r  = r % pw;
        return r[63:0];
    endfunction

    task automatic push_exp(input logic [63:0] ev);
        q.push_back('{data: ev, pt: pt_m, grp: grp_m,
                      last: (pt_m == 4'hF) && (grp_m == 6'h3F), acc: adv_cnt + 1});
        pt_m = pt_m + 4'd1;
        if (pt_m == 4'd0) grp_m = grp_m + 6'd1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [63:0] t,
                         input logic [2:0] sc, input logic c);
        @(negedge clk);
        in_valid = v; in_data = d; tf = t; stage_counter = sc; cen = c;
        if (v && !c) push_exp((sc != 3'd0 || pt_m == 4'd0) ? d : mod_mul(d, t));
    endtask

    task automatic drive_x(input logic [63:0] d, input logic [63:0] t, input logic [63:0] ev);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; tf = t; stage_counter = 3'd0; cen = 1'b0;
        push_exp(ev);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; cen = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check_val("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Called just after a negedge; the reset covers exactly one rising edge.
    task automatic pulse_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        q.delete(); held_v = 1'b0; pt_m = '0; grp_m = '0;
        #1 check_val("rst_async_valid", 64'(out_valid), 64'd0);
        check_val("rst_async_pt", 64'(out_pt_idx), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!cen && !rst_n) adv_cnt++;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (adv_cnt != adv_seen) begin
                adv_seen = adv_cnt;
                exp_v = (q.size() != 0) && (q[0].acc + 2 == adv_cnt);
                check_val("out_valid", 64'(out_valid), 64'(exp_v));
                if (exp_v) begin
                    e = q.pop_front();
                    check_val("out_data", out_data, e.data);
                    check_val("out_pt_idx", 64'(out_pt_idx), 64'(e.pt));
                    check_val("out_grp_idx", 64'(out_grp_idx), 64'(e.grp));
                    check_val("out_last", 64'(out_last), 64'(e.last));
                    if (out_last) last_cnt++;
                    held_v = 1'b1;
                    held_d = e.data;
                end else begin
                    check_val("out_last_idle", 64'(out_last), 64'd0);
                    held_v = 1'b0;
                end
            end else begin
                check_val("hold_valid", 64'(out_valid), 64'(held_v));
                if (held_v) check_val("hold_data", out_data, held_d);
            end
        end else begin
            adv_seen = adv_cnt;
        end
    end

    initial begin
        logic [63:0] d;
        logic [63:0] t;

        repeat (3) @(negedge clk);
        #1;
        check_val("reset_valid", 64'(out_valid), 64'd0);
        check_val("reset_data", out_data, 64'd0);
        check_val("reset_pt", 64'(out_pt_idx), 64'd0);
        check_val("reset_grp", 64'(out_grp_idx), 64'd0);
        check_val("reset_last", 64'(out_last), 64'd0);
        rst_n = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) drive(1'b1, 64'd5, TF, 3'd0, 1'b0);

        drive(1'b1, 64'd7, 64'd3, 3'd0, 1'b0);
        drive_x(P - 64'd1, P - 64'd1, 64'd1);
        drive_x(64'h0000000100000000, 64'h0000000100000000, 64'h00000000FFFFFFFF);
        drive_x(64'h0001000000000000, 64'h0001000000000000, 64'hFFFFFFFF00000000);
        drive_x(64'hFFFFFFFFFFFFFFFF, 64'd1, 64'h00000000FFFFFFFE);
        drain();

        while (pt_m != 4'd0) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'd2, 1'b0);
        drain();

        for (int i = 0; i < 4; i++) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0);
        d = {$urandom, $urandom};
        t = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) drive(1'b1, d, t, 3'd0, 1'b1);
        drive(1'b1, d, t, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0);
        drain();

        for (int i = 0; i < 3; i++) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0);
        drive(1'b0, 64'd0, 64'd0, 3'd0, 1'b0);
        pulse_reset();
        drive(1'b1, 64'h0000000000001234, TF, 3'd0, 1'b0);
        drain();

        pulse_reset();
        last_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            d = {$urandom, $urandom};
            t = {$urandom, $urandom};
            if (i % 8 == 3) d = P + 64'($urandom_range(0, 1000));
            if (i % 11 == 5) t = P + 64'($urandom_range(0, 1000));
            drive(1'b1, d, t, 3'd0, 1'b0);
        end
        drain();
        check_val("last_pulses", 64'(last_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
